// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: pointer width,
// Gray encode/decode and the mask used by the full comparison.
package async_fifo_wr_ctrl_pkg;

  // Functions work on a fixed wide vector; callers zero-extend and truncate.
  localparam int GW = 32;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [GW-1:0] gray_enc(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down; zero extension leaves the result intact.
  function automatic logic [GW-1:0] gray_dec(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Top two bits of a pw-bit Gray pointer set: full when the write pointer
  // equals the read pointer with exactly those two bits flipped.
  function automatic logic [GW-1:0] full_mask(input int pw);
    logic [GW-1:0] m;
    m = '0;
    m[pw-1] = 1'b1;
    m[pw-2] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_ptr_sync2.sv
// Two-flop synchronizer for a Gray pointer crossing clock domains.
module ptr_sync2 #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1_q, q1_d;
  logic [W-1:0] q2_q, q2_d;

  // Next-state: shift the incoming pointer through both stages.
  always_comb begin
    q1_d = d;
    q2_d = q1_q;
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchronizer, registered full, sticky overflow, fill level.
module async_fifo_wr_ctrl
  import async_fifo_wr_ctrl_pkg::*;
#(
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [addr_width:0]   rd_ptr_gray,
  output logic                  wr_accept,
  output logic [addr_width-1:0] wr_addr,
  output logic [addr_width:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  overflow,
  output logic [addr_width:0]   wr_level
);

  localparam int PW = ptr_w(addr_width);
  localparam logic [PW-1:0] FULL_MASK = PW'(full_mask(PW));

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wr_level_q, wr_level_d;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin_sync;
  logic          inc;

  ptr_sync2 #(.W(PW)) u_rsync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_ptr_gray),
    .q     (rq2)
  );

  // Accept gated by reset so no strobe reaches the RAM while in reset.
  assign inc = wr_en & ~full_q & rst_n;

  // Next pointer, Gray code, full compare, level and overflow.
  always_comb begin
    wbin_d     = wbin_q + PW'(inc);
    wgray_d    = PW'(gray_enc(GW'(wbin_d)));
    rbin_sync  = PW'(gray_dec(GW'(rq2)));
    full_d     = (wgray_d == (rq2 ^ FULL_MASK));
    wr_level_d = wbin_d - rbin_sync;
    overflow_d = overflow_q | (wr_en & full_q);
  end

  // State registers; Gray output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_level_q <= '0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      wr_level_q <= wr_level_d;
    end
  end

  assign wr_accept   = inc;
  assign wr_addr     = wbin_q[addr_width-1:0];
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign overflow    = overflow_q;
  assign wr_level    = wr_level_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (addr_width = 5).
module tb_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [5:0] rd_ptr_gray;
  logic       wr_accept;
  logic [4:0] wr_addr;
  logic [5:0] wr_ptr_gray;
  logic       full;
  logic       overflow;
  logic [5:0] wr_level;

  int checks = 0;
  int errors = 0;

  async_fifo_wr_ctrl #(.addr_width(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_accept   (wr_accept),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .overflow    (overflow),
    .wr_level    (wr_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [5:0] rd;
    logic       acc;
    logic [4:0] addr;
    logic [5:0] gray;
    logic       full;
    logic [5:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tv[7];

  function automatic logic [5:0] g(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_ptr_gray = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [5:0] rb, wb_m, prev, occ;

    //            wr_en rd        acc addr gray       full lvl ovf
    tv[0] = '{1'b1, 6'd0, 1'b1, 5'd1, 6'b000001, 1'b0, 6'd1, 1'b0};
    tv[1] = '{1'b0, 6'd0, 1'b0, 5'd1, 6'b000001, 1'b0, 6'd1, 1'b0};
    tv[2] = '{1'b1, 6'd0, 1'b1, 5'd2, 6'b000011, 1'b0, 6'd2, 1'b0};
    tv[3] = '{1'b1, 6'd1, 1'b1, 5'd3, 6'b000010, 1'b0, 6'd3, 1'b0};
    tv[4] = '{1'b0, 6'd1, 1'b0, 5'd3, 6'b000010, 1'b0, 6'd3, 1'b0};
    tv[5] = '{1'b0, 6'd1, 1'b0, 5'd3, 6'b000010, 1'b0, 6'd2, 1'b0};
    tv[6] = '{1'b1, 6'd1, 1'b1, 5'd4, 6'b000110, 1'b0, 6'd3, 1'b0};

    // Reset held with a pending write request.
    rst_n = 1'b0;
    wr_en = 1'b1;
    rd_ptr_gray = '0;
    tick();
    tick();
    chk("rst_accept", wr_accept, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_gray", wr_ptr_gray, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", wr_level, 0);
    rst_n = 1'b1;
    #1;
    chk("first_addr", wr_addr, 0);
    chk("first_accept", wr_accept, 1);

    // Table: per-vector accept before the edge, registered outputs after.
    for (int i = 0; i < 7; i++) begin
      wr_en = tv[i].wr_en;
      rd_ptr_gray = tv[i].rd;
      #1;
      chk($sformatf("tv%0d_acc", i), wr_accept, tv[i].acc);
      tick();
      chk($sformatf("tv%0d_addr", i), wr_addr, tv[i].addr);
      chk($sformatf("tv%0d_gray", i), wr_ptr_gray, tv[i].gray);
      chk($sformatf("tv%0d_full", i), full, tv[i].full);
      chk($sformatf("tv%0d_lvl", i), wr_level, tv[i].lvl);
      chk($sformatf("tv%0d_ovf", i), overflow, tv[i].ovf);
    end

    // Fill 32 entries with the reader parked at 0.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      #1;
      chk($sformatf("fill_addr%0d", i), wr_addr, i);
      chk($sformatf("fill_acc%0d", i), wr_accept, 1);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_level", wr_level, 32);
    chk("fill_gray", wr_ptr_gray, 6'b110000);
    #1;
    chk("ovr_accept", wr_accept, 0);
    tick();
    chk("ovr_flag", overflow, 1);
    chk("ovr_addr", wr_addr, 0);
    chk("ovr_gray", wr_ptr_gray, 6'b110000);

    // Drain visibility: one read, full drops after the third edge.
    wr_en = 1'b0;
    rd_ptr_gray = 6'b000001;
    tick();
    chk("drain_e1_full", full, 1);
    tick();
    chk("drain_e2_full", full, 1);
    tick();
    chk("drain_e3_full", full, 0);
    chk("drain_e3_level", wr_level, 31);

    // Read pointer to 15 gives level 17; overflow still sticky.
    rd_ptr_gray = g(6'd15);
    tick();
    tick();
    tick();
    chk("lvl17", wr_level, 17);
    chk("lvl17_ovf", overflow, 1);

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(negedge clk);
    wr_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_level", wr_level, 0);
    chk("async_ovf", overflow, 0);
    chk("async_gray", wr_ptr_gray, 0);
    chk("async_addr", wr_addr, 0);
    chk("async_accept", wr_accept, 0);
    tick();

    // Wrap: reader tracks the writer, 64 writes roll the pointer over.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      rd_ptr_gray = g(6'(i));
      wr_en = 1'b1;
      tick();
      chk($sformatf("wrap_full%0d", i), full, 0);
      if (i == 62) chk("wrap_gray63", wr_ptr_gray, 6'b100000);
      if (i == 63) chk("wrap_gray0", wr_ptr_gray, 6'b000000);
    end

    // Random traffic with a legal reader: Gray steps and capacity bound.
    do_reset();
    rb = '0;
    wb_m = '0;
    prev = '0;
    for (int c = 0; c < 10000; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      if (rb != wb_m && $urandom_range(0, 1) == 1) rb = rb + 6'd1;
      rd_ptr_gray = g(rb);
      #1;
      if (full && wr_accept) begin
        checks++;
        errors++;
        $display("FAIL rand_accept_full cycle=%0d actual=1 expected=0", c);
      end
      if (wr_accept) wb_m = wb_m + 6'd1;
      tick();
      checks++;
      if ($countones(wr_ptr_gray ^ prev) > 1) begin
        errors++;
        $display("FAIL rand_hamming cycle=%0d actual=%b prev=%b expected<=1 bit", c, wr_ptr_gray, prev);
      end
      chk("rand_gray", wr_ptr_gray, g(wb_m));
      occ = wb_m - rb;
      checks++;
      if (occ > 6'd32) begin
        errors++;
        $display("FAIL rand_occupancy cycle=%0d actual=%0d expected<=32", c, occ);
      end
      prev = wr_ptr_gray;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-domain controller for the dual-clock FIFO. It keeps the binary write pointer and presents it to the read domain as a registered Gray code. It also brings the read domain's Gray pointer into the write clock through a two-flop synchronizer and derives a registered `full` flag, a sticky `overflow` flag and a fill-level estimate. It is the Gray-encoding counterpart of the read-side pointer decoder and drives the FIFO RAM write port directly.

## Interface
Parameters:
- `addr_width`, 5: RAM address width. Depth is 2^addr_width. Pointers are addr_width+1 bits wide.

Ports:
- `clk`  input  1  write-domain clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `wr_en`  input  1  write request from the producer.
- `rd_ptr_gray`  input  addr_width+1  read pointer in Gray code, from the read clock domain (asynchronous to `clk`).
- `wr_accept`  output  1  RAM write strobe, equal to `wr_en & ~full` (combinational).
- `wr_addr`  output  addr_width  RAM write address, the low bits of the binary write pointer.
- `wr_ptr_gray`  output  addr_width+1  registered Gray write pointer, sent to the read domain.
- `full`  output  1  registered full flag.
- `overflow`  output  1  sticky flag, set by `wr_en` while `full`.
- `wr_level`  output  addr_width+1  registered occupancy estimate, 0..2^addr_width.

## Operation
- State registers:
  - `wbin`: binary write pointer.
  - `wgray`: Gray write pointer.
  - `rq1`, `rq2`: synchronizer stages.
  - `full`, `overflow`, `wr_level`.
- Reset values: every register and output is 0.
- Accept: `inc = wr_en & ~full`.
- Next pointers:
  - `wbin_next = wbin + inc`, modulo 2^(addr_width+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- `wgray` is always loaded from `wgray_next`. There is never a combinational path from `wbin` to `wr_ptr_gray`.
- Full test: `full_next = (wgray_next == {~rq2[top:top-1], rq2[top-2:0]})`, i.e. the top two bits inverted, rest equal.
- Level:
  - `rbin_sync` is the Gray-to-binary conversion of `rq2`, by XOR prefix from the MSB down.
  - `wr_level_next = wbin_next - rbin_sync`, modulo 2^(addr_width+1).
- Overflow:
  - Set when `wr_en & full`.
  - Cleared only by reset.
  - A refused write does not change any pointer.
- No state machine. The block is a counter, an encoder, a synchronizer and comparators.
- Wrap-around: the pointer rolls from 2^(addr_width+1)-1 to 0. The MSB toggles on every pass, which is how full is distinguished from empty.

## Timing
- An accepted write at edge k:
  - The RAM writes at `wr_addr` on edge k.
  - `wr_addr`, `wr_ptr_gray`, `full` and `wr_level` reflect the new pointer after edge k.
- Write latency is 1 cycle. The full that results from a write is visible in the very next cycle, so no write is ever accepted into a full RAM.
- Read-pointer propagation:
  - A change on `rd_ptr_gray` stable before edge k is captured in `rq1` at k and in `rq2` at k+1.
  - It is reflected in `full` and `wr_level` after edge k+2.
- `full` and `wr_level` are therefore conservative: they may stay asserted or high for up to 3 cycles after a read.
- `wr_ptr_gray` changes by at most one bit per `clk` edge. Verification must assert this.
- Simultaneous write and read-pointer update: the write uses the old `rq2`, and the read is accounted for 2 edges later.
- Reset asserted mid-operation:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - `wr_accept` is forced low while `rst_n` is low.
- The read domain must be reset in the same window. Resetting the two domains independently is not supported.

## Structure
- Shared package holds:
  - the pointer-width function `addr_width+1`;
  - the Gray encode and decode functions;
  - the full-compare mask constant (top two bits set).
- One sub-module, `ptr_sync2`:
  - parameterised-width two-flop synchronizer with asynchronous active-low reset to 0;
  - reused by the read-side controller for `wr_ptr_gray`.

## Test plan
- Reset: hold `rst_n`=0 with `wr_en`=1 → all outputs 0, `wr_accept`=0. Release → first write goes to `wr_addr`=0.
- Fill (addr_width=5, `rd_ptr_gray`=0): 32 back-to-back writes → `wr_addr` runs 0..31, `full`=1 and `wr_level`=32 after the 32nd, and the 33rd `wr_en` gives `wr_accept`=0 with `overflow`=1.
- Drain visibility: from full, drive `rd_ptr_gray`=6'b000001 → `full` deasserts exactly after the third `clk` edge, and `wr_level`=31.
- Wrap: with the read pointer tracking, write 64 entries → `wr_ptr_gray` goes 6'b100000 (bin 63) → 6'b000000, and `full` never asserts.
- Gray property: random `wr_en` and random legal read-pointer progression for 10k cycles → Hamming distance of `wr_ptr_gray` between edges ≤1, with no accept while full.
- Mid-operation reset: assert `rst_n`=0 asynchronously at level 17 → outputs clear without a clock edge, and `overflow` clears.
